spi_memory_burst: RTL and testbench
===================================

SPI_MEMORY_BURST -- requirements
Module: spi_memory_burst

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, memory address bits; depth = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8, bits per memory word and per SPI data word.
REQ-003 Parameter CPOL, default 0, sclk idle level.
REQ-004 Parameter CPHA, default 0; 0 = sample on leading sclk edge, 1 = sample on trailing edge.
REQ-005 Parameter SYNC_STAGES, default 2, flip-flop stages on each SPI input pin (min 2).
REQ-006 clk  input  1  system clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 sclk_pin  input  1  SPI serial clock, asynchronous to clk.
REQ-009 cs_pin  input  1  SPI chip select, active low.
REQ-010 mosi_pin  input  1  SPI serial data in, MSB first.
REQ-011 miso_pin  output  1  SPI serial data out, MSB first.
REQ-012 miso_oe  output  1  high while the block drives read data on miso_pin.
REQ-013 leds  output  4  low 4 bits of the most recently written data word.
REQ-014 busy  output  1  high while a frame is active (cs_pin low, synchronised).

Function
REQ-015 sclk_pin, cs_pin, mosi_pin SHALL pass through SYNC_STAGES synchronisers; sclk edges detected from the synchronised signal only.
REQ-016 Sample edge = rising if CPOL xor CPHA = 0, else falling; shift edge = opposite edge.
REQ-017 Supported sclk: each sclk half-period at least SYNC_STAGES+3 clk cycles; faster sclk is undefined.
REQ-018 FSM states: IDLE, ADDR, WRITE, READ.
REQ-019 IDLE -> ADDR on synchronised cs_pin falling; bit counter cleared, shift register cleared.
REQ-020 ADDR: ADDR_WIDTH address bits then one R/W bit sampled MSB first; R/W = 0 -> WRITE, 1 -> READ.
REQ-021 WRITE: every DATA_WIDTH sampled bits, word written to mem[addr] within 1 clk of the final sample edge; leds updated same cycle; addr increments.
REQ-022 READ: mem[addr] loaded into output shifter within 1 clk of the R/W sample; miso_pin presents MSB on the first shift edge after that (CPHA=1) or immediately after load (CPHA=0); one bit per subsequent shift edge.
REQ-023 READ burst: after the last bit of a word is shifted, addr increments and the next word loads so its MSB appears on the next shift edge without gaps.
REQ-024 Address increment SHALL wrap from 2**ADDR_WIDTH-1 to 0.
REQ-025 Synchronised cs_pin rising in any state -> IDLE within 1 clk; partial write word discarded, memory unchanged; partial address discarded.
REQ-026 miso_oe high only in READ; miso_pin = 0 whenever miso_oe is low.
REQ-027 busy = 1 in ADDR, WRITE, READ; 0 in IDLE.
REQ-028 mosi_pin ignored in READ; write and read never occur in the same frame.
REQ-029 sclk edges while cs_pin high SHALL have no effect.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, miso_pin = 0, miso_oe = 0, busy = 0, leds = 4'h0, counters and shifters to 0.
REQ-031 Memory contents SHALL not be cleared by reset; a frame in progress at reset is aborted and not committed.
REQ-032 After rst_n rises, a new frame requires a fresh cs_pin falling edge; cs_pin already low is ignored until it goes high.

Verification
REQ-033 Default params, mode 0: write 0xAA to addr 0x1D, then read 0x1D -> miso bits 1,0,1,0,1,0,1,0; leds = 4'hA.
REQ-034 Burst write 0x11,0x22,0x33 at addr 0x7E in one frame, then burst read 3 words from 0x7E -> 0x11,0x22,0x33; mem[0x00] = 0x33 (wrap).
REQ-035 Write addr 0x05 = 0x5C, then new frame writing addr 0x05 with only 4 data bits, cs high -> read 0x05 returns 0x5C; leds = 4'hC.
REQ-036 rst_n pulsed low mid-data of a write to 0x10 -> outputs at reset values same cycle, mem[0x10] unchanged, next complete frame works.
REQ-037 Instance CPOL=1, CPHA=1, ADDR_WIDTH=4, DATA_WIDTH=16: write 0xBEEF to addr 0xF, read back 0xBEEF; burst continuation reads mem[0x0].
REQ-038 During any write frame miso_oe = 0 and miso_pin = 0; during read data phase miso_oe = 1.

Source files
------------

// File: rtl/spi_memory_burst.sv
// SPI slave fronting a word-addressed memory with auto-incrementing burst reads and writes.
// SPI pins are synchronised into clk; all protocol decisions use the synchronised sclk edges.
module spi_memory_burst #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic [3:0] leds,
  output logic       busy
);
  localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;
  localparam int unsigned SH_W        = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int unsigned CNT_W       = $clog2(SH_W + 1);
  localparam bit          SCLK_IDLE   = (CPOL != 0);
  localparam bit          SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
  localparam bit          LATE_PHASE  = (CPHA != 0);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WRITE, S_READ} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   samp_edge, shift_edge, cs_fall;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, addr_inc;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SH_W-1:0]        shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  out_q, out_d, rd_word;
  logic                   pend_q, pend_d;
  logic                   miso_q, miso_d;
  logic [3:0]             leds_q, leds_d;
  logic                   miso_oe_q, busy_q;

  logic [DATA_WIDTH-1:0]  mem_q [0:DEPTH-1];
  logic                   mem_we;
  logic [DATA_WIDTH-1:0]  mem_wdata;

  // cs synchroniser resets to "selected" so a cs already low at reset release never starts a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= SCLK_IDLE;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_pin};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign samp_edge  = SAMPLE_RISE ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);
  assign shift_edge = SAMPLE_RISE ? (~sclk_s & sclk_prev_q) : (sclk_s & ~sclk_prev_q);
  assign cs_fall    = cs_prev_q & ~cs_s;
  assign addr_inc   = addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cs_fall) state_d = S_ADDR;
      S_ADDR: begin
        if (cs_s) state_d = S_IDLE;
        else if (samp_edge && cnt_q == CNT_W'(ADDR_WIDTH)) state_d = mosi_s ? S_READ : S_WRITE;
      end
      S_WRITE: if (cs_s) state_d = S_IDLE;
      S_READ:  if (cs_s) state_d = S_IDLE;
    endcase
  end

  // Datapath next values; pend marks that the master has sampled the bit currently on miso
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    out_d   = out_q;
    pend_d  = pend_q;
    miso_d  = 1'b0;
    leds_d  = leds_q;
    mem_we  = 1'b0;
    rd_word = mem_q[addr_q];
    unique case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          cnt_d   = '0;
          shift_d = '0;
          out_d   = '0;
          pend_d  = 1'b0;
        end
      end
      S_ADDR: begin
        if (!cs_s && samp_edge) begin
          shift_d = SH_W'({shift_q, mosi_s});
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_WIDTH)) begin
            addr_d  = shift_q[ADDR_WIDTH-1:0];
            shift_d = '0;
            cnt_d   = '0;
            if (mosi_s) begin
              rd_word = mem_q[shift_q[ADDR_WIDTH-1:0]];
              if (LATE_PHASE) begin
                out_d  = rd_word;
                pend_d = 1'b1;
              end else begin
                miso_d = rd_word[DATA_WIDTH-1];
                out_d  = {rd_word[DATA_WIDTH-2:0], 1'b0};
                cnt_d  = CNT_W'(1);
                pend_d = 1'b0;
              end
            end
          end
        end
      end
      S_WRITE: begin
        if (!cs_s && samp_edge) begin
          shift_d = SH_W'({shift_q, mosi_s});
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            mem_we = 1'b1;
            leds_d = shift_d[3:0];
            addr_d = addr_inc;
            cnt_d  = '0;
          end
        end
      end
      S_READ: begin
        miso_d = miso_q;
        if (cs_s) begin
          miso_d = 1'b0;
        end else if (samp_edge) begin
          pend_d = 1'b1;
        end else if (shift_edge && pend_q) begin
          pend_d = 1'b0;
          miso_d = out_q[DATA_WIDTH-1];
          out_d  = {out_q[DATA_WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            addr_d = addr_inc;
            out_d  = mem_q[addr_inc];
            cnt_d  = '0;
          end
        end
      end
    endcase
    mem_wdata = shift_d[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      out_q     <= '0;
      pend_q    <= 1'b0;
      miso_q    <= 1'b0;
      leds_q    <= 4'h0;
      miso_oe_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      out_q     <= out_d;
      pend_q    <= pend_d;
      miso_q    <= miso_d & (state_d == S_READ);
      leds_q    <= leds_d;
      miso_oe_q <= (state_d == S_READ);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // Storage survives reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= mem_wdata;
  end

  assign miso_pin = miso_q;
  assign miso_oe  = miso_oe_q;
  assign leds     = leds_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_spi_memory_burst.sv
// Directed bench: a mode-0 default instance and a mode-3 16-bit instance driven by bit-level SPI masters.
module tb_spi_memory_burst;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic a_sclk, a_cs, a_mosi, a_miso, a_oe, a_busy;
  logic [3:0] a_leds;
  logic b_sclk, b_cs, b_mosi, b_miso, b_oe, b_busy;
  logic [3:0] b_leds;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] r;
  logic        ok, bs, mi, oe;
  logic [6:0]  abort_addr;

  spi_memory_burst u_a (
    .clk(clk), .rst_n(rst_n), .sclk_pin(a_sclk), .cs_pin(a_cs), .mosi_pin(a_mosi),
    .miso_pin(a_miso), .miso_oe(a_oe), .leds(a_leds), .busy(a_busy)
  );

  spi_memory_burst #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .sclk_pin(b_sclk), .cs_pin(b_cs), .mosi_pin(b_mosi),
    .miso_pin(b_miso), .miso_oe(b_oe), .leds(b_leds), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mode 0 bit: data set while sclk low, master samples miso just before the rising edge
  task automatic a_bit(input logic mo, output logic m, output logic o);
    a_mosi = mo;
    #HALF;
    m = a_miso;
    o = a_oe;
    a_sclk = 1'b1;
    #HALF;
    a_sclk = 1'b0;
  endtask

  task automatic a_frame(input logic [6:0] addr, input logic rw, input int nbits,
                         input logic [31:0] wdat, output logic [31:0] rdat,
                         output logic oe_ok, output logic busy_seen);
    logic m, o;
    rdat = '0;
    oe_ok = 1'b1;
    a_cs = 1'b0;
    #HALF;
    for (int i = 6; i >= 0; i--) a_bit(addr[i], m, o);
    busy_seen = a_busy;
    a_bit(rw, m, o);
    for (int i = nbits - 1; i >= 0; i--) begin
      a_bit(wdat[i], m, o);
      rdat = {rdat[30:0], m};
      if (rw) oe_ok = oe_ok & (o === 1'b1);
      else    oe_ok = oe_ok & (o === 1'b0) & (m === 1'b0);
    end
    #HALF;
    a_cs = 1'b1;
    #(4 * HALF);
  endtask

  // Mode 3 bit: falling edge shifts, rising edge samples
  task automatic b_bit(input logic mo, output logic m, output logic o);
    b_sclk = 1'b0;
    b_mosi = mo;
    #HALF;
    m = b_miso;
    o = b_oe;
    b_sclk = 1'b1;
    #HALF;
  endtask

  task automatic b_frame(input logic [3:0] addr, input logic rw, input int nbits,
                         input logic [31:0] wdat, output logic [31:0] rdat, output logic oe_ok);
    logic m, o;
    rdat = '0;
    oe_ok = 1'b1;
    b_cs = 1'b0;
    #HALF;
    for (int i = 3; i >= 0; i--) b_bit(addr[i], m, o);
    b_bit(rw, m, o);
    for (int i = nbits - 1; i >= 0; i--) begin
      b_bit(wdat[i], m, o);
      rdat = {rdat[30:0], m};
      if (rw) oe_ok = oe_ok & (o === 1'b1);
      else    oe_ok = oe_ok & (o === 1'b0) & (m === 1'b0);
    end
    #HALF;
    b_cs = 1'b1;
    #(4 * HALF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    a_sclk = 1'b0; a_cs = 1'b1; a_mosi = 1'b0;
    b_sclk = 1'b1; b_cs = 1'b1; b_mosi = 1'b0;
    abort_addr = 7'h10;
    #23;
    chk("rst_miso", 32'(a_miso), 32'h0);
    chk("rst_oe",   32'(a_oe),   32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_leds", 32'(a_leds), 32'h0);
    #40 rst_n = 1'b1;
    #(4 * HALF);

    // Single write / read
    a_frame(7'h1D, 1'b0, 8, 32'hAA, r, ok, bs);
    chk("wr1d_leds", 32'(a_leds), 32'hA);
    chk("wr1d_oe_quiet", 32'(ok), 32'h1);
    chk("wr1d_busy", 32'(bs), 32'h1);
    a_frame(7'h1D, 1'b1, 8, 32'hFF, r, ok, bs);
    chk("rd1d_data", r, 32'hAA);
    chk("rd1d_oe", 32'(ok), 32'h1);
    chk("rd1d_end_oe", 32'(a_oe), 32'h0);
    chk("rd1d_end_miso", 32'(a_miso), 32'h0);
    chk("rd1d_leds", 32'(a_leds), 32'hA);

    // sclk activity with cs high is ignored
    for (int i = 0; i < 10; i++) begin
      a_mosi = 1'b1;
      #HALF a_sclk = 1'b1;
      #HALF a_sclk = 1'b0;
    end
    #(2 * HALF);
    chk("cs_high_busy", 32'(a_busy), 32'h0);
    chk("cs_high_leds", 32'(a_leds), 32'hA);

    // Burst across the address wrap
    a_frame(7'h7E, 1'b0, 24, 32'h112233, r, ok, bs);
    chk("burst_wr_leds", 32'(a_leds), 32'h3);
    chk("burst_wr_oe", 32'(ok), 32'h1);
    a_frame(7'h7E, 1'b1, 24, 32'h0, r, ok, bs);
    chk("burst_rd_data", r, 32'h112233);
    chk("burst_rd_oe", 32'(ok), 32'h1);
    a_frame(7'h00, 1'b1, 8, 32'h0, r, ok, bs);
    chk("wrap_rd_00", r, 32'h33);

    // Partial word is discarded
    a_frame(7'h05, 1'b0, 8, 32'h5C, r, ok, bs);
    chk("wr05_leds", 32'(a_leds), 32'hC);
    a_frame(7'h05, 1'b0, 4, 32'hF, r, ok, bs);
    chk("partial_leds", 32'(a_leds), 32'hC);
    a_frame(7'h05, 1'b1, 8, 32'h0, r, ok, bs);
    chk("partial_rd05", r, 32'h5C);
    chk("partial_rd_leds", 32'(a_leds), 32'hC);

    // Mode 3, 16-bit instance, burst continues from 0xF into 0x0
    b_frame(4'h0, 1'b0, 16, 32'h1234, r, ok);
    chk("b_wr0_leds", 32'(b_leds), 32'h4);
    b_frame(4'hF, 1'b0, 16, 32'hBEEF, r, ok);
    chk("b_wrf_leds", 32'(b_leds), 32'hF);
    chk("b_wrf_oe_quiet", 32'(ok), 32'h1);
    b_frame(4'hF, 1'b1, 32, 32'h0, r, ok);
    chk("b_rd_burst", r, 32'hBEEF1234);
    chk("b_rd_oe", 32'(ok), 32'h1);
    chk("b_end_busy", 32'(b_busy), 32'h0);

    // Reset in the middle of a write's data phase
    a_frame(7'h10, 1'b0, 8, 32'h3C, r, ok, bs);
    chk("wr10_leds", 32'(a_leds), 32'hC);
    a_cs = 1'b0;
    #HALF;
    for (int i = 6; i >= 0; i--) a_bit(abort_addr[i], mi, oe);
    a_bit(1'b0, mi, oe);
    for (int i = 0; i < 4; i++) a_bit(1'b1, mi, oe);
    chk("pre_rst_busy", 32'(a_busy), 32'h1);
    #20 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(a_busy), 32'h0);
    chk("midrst_oe",   32'(a_oe),   32'h0);
    chk("midrst_miso", 32'(a_miso), 32'h0);
    chk("midrst_leds", 32'(a_leds), 32'h0);
    #30 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) a_bit(1'b1, mi, oe);
    chk("cs_low_after_rst_busy", 32'(a_busy), 32'h0);
    #HALF;
    a_cs = 1'b1;
    #(4 * HALF);
    a_frame(7'h10, 1'b1, 8, 32'h0, r, ok, bs);
    chk("rd10_after_rst", r, 32'h3C);
    chk("rd10_busy", 32'(bs), 32'h1);
    chk("rd10_leds", 32'(a_leds), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
